pc_unit: RTL
============

# pc_unit

Parametrised fetch program counter with stall, prioritised redirect (exception, return, branch/jump) and an internal return-address stack (RAS). It sits at the head of the IF stage in place of the single-width fixed-step counter. It supplies the fetch address and a fetch-valid strobe to instruction memory, and takes redirect requests from the EX/MEM stages.

## Interface

- PC_WIDTH, 32, address width.
- RESET_VECTOR, 0, first fetch address after reset.
- EXC_VECTOR, 32'h80, exception handler address (low PC_WIDTH bits used).
- STEP, 4, sequential increment; power of 2, ≥1.
- RAS_DEPTH, 4, RAS entries; power of 2, ≥2.

- pcu_clk  in  1  clock, rising edge.
- pcu_rst  in  1  synchronous, active-high reset.
- pcu_i_ce  in  1  fetch enable from downstream.
- pcu_i_stall  in  1  hazard stall; blocks advance.
- pcu_i_exc  in  1  exception redirect to EXC_VECTOR; flushes RAS.
- pcu_i_change_pc  in  1  branch/jump redirect to pcu_i_pc.
- pcu_i_pc  in  PC_WIDTH  branch/jump target; also return fallback target.
- pcu_i_call  in  1  push pcu_i_link onto RAS.
- pcu_i_link  in  PC_WIDTH  return address to push.
- pcu_i_ret  in  1  pop RAS and redirect to popped address.
- pcu_o_pc  out  PC_WIDTH  current fetch address (registered).
- pcu_o_ce  out  1  pcu_o_pc valid this cycle.
- pcu_o_ras_count  out  clog2(RAS_DEPTH+1)  occupied RAS entries.
- pcu_o_underflow  out  1  one-cycle pulse: ret with empty RAS.
- pcu_o_misalign  out  1  one-cycle pulse: redirect target had nonzero low log2(STEP) bits.

## Operation

- Internal next_pc register holds the address to issue on the next advance. advance = pcu_i_ce & ~pcu_i_stall.
- On advance: pcu_o_pc <= next_pc, pcu_o_ce <= 1. Without advance: pcu_o_pc holds, pcu_o_ce <= 0.
- next_pc update priority, highest first:
  1. pcu_i_exc → EXC_VECTOR.
  2. pcu_i_ret: RAS non-empty → top entry; RAS empty → pcu_i_pc, plus underflow pulse.
  3. pcu_i_change_pc → pcu_i_pc.
  4. advance → next_pc + STEP, modulo 2^PC_WIDTH (wraps silently).
  5. otherwise hold.
- Redirects apply whether or not advance is true. A redirect in an advance cycle issues the old next_pc, and the target issues on the following advance.
- Redirect targets (ret, change_pc) get their low log2(STEP) bits forced to 0. If any such bit was 1, pcu_o_misalign pulses. EXC_VECTOR is used as given.
- Exception: pcu_o_ce <= 0 that cycle even if advance; RAS count <= 0; call/ret that cycle ignored.
- RAS is a circular buffer with top pointer and count:
  - Push (call only): write link at ptr+1, ptr++, count = min(count+1, RAS_DEPTH). Push when full overwrites the oldest entry.
  - Pop (ret only, count>0): read top, ptr--, count--.
  - call & ret in the same cycle: redirect to the old top, then overwrite top with link; ptr and count unchanged. If empty, behaves as push, with underflow fallback redirect.
- A lower-priority redirect asserted together with a higher one is dropped. Call with change_pc both take effect (push + redirect).

## Timing

- Reset (sync, pcu_rst high at edge): next_pc = RESET_VECTOR, pcu_o_pc = 0, pcu_o_ce = 0, RAS count = 0, pointer = 0, pulses = 0. Reset overrides all inputs. Mid-operation reset discards pending redirects and RAS contents.
- First fetch: RESET_VECTOR appears on pcu_o_pc, with pcu_o_ce=1, one edge after the first advance cycle following reset release.
- Redirect-to-issue latency: target on pcu_o_pc at the first advance edge after the redirect edge, minimum 2 edges from request.
- pcu_o_underflow and pcu_o_misalign are registered and high exactly one cycle after the causing edge.
- pcu_o_ras_count is registered and reflects push/pop of the previous edge.

## Test plan

- Reset, then ce=1 steady (STEP=4) → pcu_o_pc 0,4,8,12 on consecutive cycles; pcu_o_ce=0 during reset and the cycle before the first issue.
- Sequence at 8: stall 2 cycles → pcu_o_pc holds 8 and pcu_o_ce=0 for 2 cycles; then resumes at 12. Same test with PC_WIDTH=8: pcu_o_pc sequence FC → 00 wraps.
- change_pc=1, pcu_i_pc=0x100 in an advance cycle while next_pc=0x20 → issues 0x20, then 0x100, 0x104. Repeat with target 0x102 → misalign pulse, issues 0x100.
- Push links 0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) → count 4. Five rets redirect to 0x50,0x40,0x30,0x20, then pcu_i_pc with underflow pulse.
- exc with change_pc and ret in the same cycle, RAS count 3 → next issue 0x80, count 0, pcu_o_ce=0 that cycle.
- call (link 0x44) and ret together, top=0x30 → redirect 0x30, top becomes 0x44, count unchanged. Reset asserted mid-stream → pcu_o_pc=0, count 0, next issue RESET_VECTOR.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch program counter with stall, prioritised redirect (exception > return > branch)
// and a circular return-address stack that overwrites its oldest entry when full.
module pc_unit #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter logic [31:0] EXC_VECTOR   = 32'h80,
  parameter int unsigned STEP         = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                               pcu_clk,
  input  logic                               pcu_rst,
  input  logic                               pcu_i_ce,
  input  logic                               pcu_i_stall,
  input  logic                               pcu_i_exc,
  input  logic                               pcu_i_change_pc,
  input  logic [PC_WIDTH-1:0]                pcu_i_pc,
  input  logic                               pcu_i_call,
  input  logic [PC_WIDTH-1:0]                pcu_i_link,
  input  logic                               pcu_i_ret,
  output logic [PC_WIDTH-1:0]                pcu_o_pc,
  output logic                               pcu_o_ce,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     pcu_o_ras_count,
  output logic                               pcu_o_underflow,
  output logic                               pcu_o_misalign
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0] LOW_MASK = PC_WIDTH'(STEP - 1);
  localparam logic [PC_WIDTH-1:0] RST_PC   = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] EXC_PC   = PC_WIDTH'(EXC_VECTOR);
  localparam logic [PC_WIDTH-1:0] STEP_PC  = PC_WIDTH'(STEP);
  localparam logic [CW-1:0]       FULL_CNT = CW'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]       r_ptr;
  logic [CW-1:0]       r_count;
  logic [PC_WIDTH-1:0] r_next_pc;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_ce;
  logic                r_underflow;
  logic                r_misalign;

  logic                w_advance;
  logic                w_empty;
  logic                w_ret;
  logic                w_call;
  logic                w_swap;
  logic                w_push;
  logic                w_pop;
  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_raw_target;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic                w_underflow;
  logic                w_misalign;
  logic [PW-1:0]       w_ptr_inc;
  logic [PW-1:0]       w_ptr_dec;

  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_ptr_dec = r_ptr - 1'b1;

  always_comb begin
    w_advance    = pcu_i_ce & ~pcu_i_stall;
    w_empty      = (r_count == '0);
    w_ret        = pcu_i_ret & ~pcu_i_exc;
    w_call       = pcu_i_call & ~pcu_i_exc;
    // call+ret on a non-empty stack replaces the top in place instead of pop-then-push
    w_swap       = w_call & w_ret & ~w_empty;
    w_push       = w_call & ~w_swap;
    w_pop        = w_ret & ~w_call & ~w_empty;
    w_redirect   = 1'b0;
    w_raw_target = pcu_i_pc;
    w_underflow  = 1'b0;
    if (w_ret) begin
      w_redirect   = 1'b1;
      w_raw_target = w_empty ? pcu_i_pc : r_ras[r_ptr];
      w_underflow  = w_empty;
    end else if (pcu_i_change_pc & ~pcu_i_exc) begin
      w_redirect   = 1'b1;
      w_raw_target = pcu_i_pc;
    end
    w_misalign = w_redirect & (|(w_raw_target & LOW_MASK));
    if (pcu_i_exc)       w_next_pc = EXC_PC;
    else if (w_redirect) w_next_pc = w_raw_target & ~LOW_MASK;
    else if (w_advance)  w_next_pc = r_next_pc + STEP_PC;
    else                 w_next_pc = r_next_pc;
  end

  always_ff @(posedge pcu_clk) begin
    if (pcu_rst) begin
      r_next_pc   <= RST_PC;
      r_pc        <= '0;
      r_ce        <= 1'b0;
      r_ptr       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_next_pc   <= w_next_pc;
      if (w_advance) r_pc <= r_next_pc;
      r_ce        <= w_advance & ~pcu_i_exc;
      r_underflow <= w_underflow;
      r_misalign  <= w_misalign;
      if (pcu_i_exc) begin
        r_count <= '0;
      end else if (w_push) begin
        r_ptr <= w_ptr_inc;
        if (r_count != FULL_CNT) r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_ptr   <= w_ptr_dec;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: a zero count makes stale entries unreachable.
  always_ff @(posedge pcu_clk) begin
    if (!pcu_rst) begin
      if (w_swap)      r_ras[r_ptr]     <= pcu_i_link;
      else if (w_push) r_ras[w_ptr_inc] <= pcu_i_link;
    end
  end

  assign pcu_o_pc        = r_pc;
  assign pcu_o_ce        = r_ce;
  assign pcu_o_ras_count = r_count;
  assign pcu_o_underflow = r_underflow;
  assign pcu_o_misalign  = r_misalign;

endmodule
